// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end with ready/valid input, shift_en stall and a gapless reload.
// Define SERIAL_LSB_FIRST_EN to emit each word LSB first instead of MSB first.
module serial_bit_feeder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             last
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cntZero;

    assign cntZero = (cnt_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode only registered state; din_ready alone looks at shift_en so a word can follow the last bit.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        din_ready  = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        last       = 1'b0;

        case (state_q)
            IDLE: begin
                din_ready = reset;
                if (din_valid) begin
                    shreg_d = din;
                    cnt_d   = CntMax;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                sout_valid = 1'b1;
`ifdef SERIAL_LSB_FIRST_EN
                sout       = shreg_q[0];
`else
                sout       = shreg_q[WIDTH-1];
`endif
                last       = cntZero;
                din_ready  = reset && cntZero && shift_en;
                if (shift_en) begin
                    if (!cntZero) begin
`ifdef SERIAL_LSB_FIRST_EN
                        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
`else
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
`endif
                        cnt_d   = cnt_q - 1'b1;
                    end else if (din_valid) begin
                        shreg_d = din;
                        cnt_d   = CntMax;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Self-checking bench for serial_bit_feeder: vector table plus scoreboard of expected serial bits.
module tb_serial_bit_feeder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             last;

    serial_bit_feeder #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .shift_en   (shift_en),
        .sout       (sout),
        .sout_valid (sout_valid),
        .last       (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             sh;
        logic             es;
        logic             ev;
        logic             el;
        logic             er;
    } vec_t;

    typedef struct {
        logic b;
        logic l;
    } bit_t;

    vec_t  vecs[$];
    bit_t  sb[$];
    int    vectors;
    int    miscompares;
    logic  expReady;
    logic [2:0] detHist;
    int    detPulses;
    int    detPos;
    int    bitIdx;

    // Bit k (0 = first on the wire) of a word in the configured order.
    function automatic logic bitOf(input logic [WIDTH-1:0] w, input int k);
`ifdef SERIAL_LSB_FIRST_EN
        return w[k];
`else
        return w[WIDTH-1-k];
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares DUT outputs against the queue model, then retires/accepts as the next edge will.
    task automatic checkOutput();
        if (sb.size() == 0) begin
            expReady = 1'b1;
            check("idle_valid", 32'(sout_valid), 32'd0);
            check("idle_sout", 32'(sout), 32'd0);
            check("idle_last", 32'(last), 32'd0);
        end else begin
            expReady = (sb.size() == 1) && shift_en;
            check("sout_valid", 32'(sout_valid), 32'd1);
            check("sout", 32'(sout), 32'(sb[0].b));
            check("last", 32'(last), 32'(sb[0].l));
        end
        check("din_ready", 32'(din_ready), 32'(expReady));
        if (sb.size() != 0 && shift_en) begin
            bit_t e;
            e = sb.pop_front();
            bitIdx++;
            detHist = {detHist[1:0], e.b};
            if (detHist == 3'b101) begin
                detPulses++;
                detPos = bitIdx;
            end
        end
        if (din_valid && expReady) begin
            for (int k = 0; k < WIDTH; k++) begin
                bit_t n;
                n.b = bitOf(din, k);
                n.l = (k == WIDTH - 1);
                sb.push_back(n);
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic sh);
        @(posedge clk);
        #1;
        din_valid = v;
        din       = d;
        shift_en  = sh;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic addWord(input logic [WIDTH-1:0] w);
        vec_t x;
        x = '{v: 1'b1, d: w, sh: 1'b1, es: 1'b0, ev: 1'b0, el: 1'b0, er: 1'b1};
        vecs.push_back(x);
        for (int k = 0; k < WIDTH; k++) begin
            x = '{v: 1'b0, d: '0, sh: 1'b1, es: bitOf(w, k), ev: 1'b1,
                  el: (k == WIDTH - 1), er: (k == WIDTH - 1)};
            vecs.push_back(x);
        end
        x = '{v: 1'b0, d: '0, sh: 1'b1, es: 1'b0, ev: 1'b0, el: 1'b0, er: 1'b1};
        vecs.push_back(x);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        detHist     = '0;
        detPulses   = 0;
        detPos      = 0;
        bitIdx      = 0;
        reset       = 1'b0;
        din         = '0;
        din_valid   = 1'b0;
        shift_en    = 1'b0;

        addWord(8'hA0);
        addWord(8'h5A);
        addWord(8'h01);
        addWord(8'h80);

        #2;
        check("por_ready", 32'(din_ready), 32'd0);
        check("por_valid", 32'(sout_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(din_ready), 32'd1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].v, vecs[i].d, vecs[i].sh);
            check($sformatf("tbl%0d_sout", i), 32'(sout), 32'(vecs[i].es));
            check($sformatf("tbl%0d_valid", i), 32'(sout_valid), 32'(vecs[i].ev));
            check($sformatf("tbl%0d_last", i), 32'(last), 32'(vecs[i].el));
            check($sformatf("tbl%0d_ready", i), 32'(din_ready), 32'(vecs[i].er));
        end

        // Back-to-back: second word offered on the first word's last bit.
        applyStimulus(1'b1, 8'hA5, 1'b1);
        for (int k = 0; k < WIDTH - 1; k++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'h3C, 1'b1);
        check("b2b_accept", 32'(din_ready), 32'd1);
        for (int k = 0; k < WIDTH; k++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        check("b2b_drained", 32'(sb.size()), 32'd0);

        // Stall for three cycles after the third bit.
        applyStimulus(1'b1, 8'hB4, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 8'hFF, 1'b0);
            check("stall_ready", 32'(din_ready), 32'd0);
            check("stall_hold", 32'(sout), 32'(bitOf(8'hB4, 3)));
        end
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 8'h00, 1'b1);
        check("stall_drained", 32'(sb.size()), 32'd0);

        // Downstream "101" detector pairing.
        detHist   = '0;
        detPulses = 0;
        detPos    = 0;
        bitIdx    = 0;
        applyStimulus(1'b1, 8'b0101_0000, 1'b1);
        bitIdx = 0;
        for (int k = 0; k < WIDTH + 1; k++) applyStimulus(1'b0, 8'h00, 1'b1);
        check("det_pulses", 32'(detPulses), 32'd1);
`ifdef SERIAL_LSB_FIRST_EN
        check("det_pos", 32'(detPos), 32'd7);
`else
        check("det_pos", 32'(detPos), 32'd4);
`endif

        // Reset mid-word aborts it immediately.
        applyStimulus(1'b1, 8'hFF, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_valid", 32'(sout_valid), 32'd0);
        check("rst_sout", 32'(sout), 32'd0);
        check("rst_ready", 32'(din_ready), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_rel_ready", 32'(din_ready), 32'd1);
        check("rst_rel_valid", 32'(sout_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
